// File: rtl/ycbcr_pkg.sv
// rtl/ycbcr_pkg.sv - BT.601 YCbCr->RGB coefficients, offsets and fixed-point widths
package ycbcr_pkg;

    localparam int DEF_DATA_WIDTH = 8;

    // Full-range coefficients, scaled by 2^8
    localparam int FULL_K_Y    = 256;
    localparam int FULL_K_RCR  = 359;
    localparam int FULL_K_GCB  = 88;
    localparam int FULL_K_GCR  = 183;
    localparam int FULL_K_BCB  = 454;
    localparam int FULL_Y_OFF  = 0;

    // Studio-range coefficients, scaled by 2^8
    localparam int STUDIO_K_Y   = 298;
    localparam int STUDIO_K_RCR = 409;
    localparam int STUDIO_K_GCB = 100;
    localparam int STUDIO_K_GCR = 208;
    localparam int STUDIO_K_BCB = 516;
    localparam int STUDIO_Y_OFF = 16;

    typedef logic signed [DEF_DATA_WIDTH+11:0] prod_t;
    typedef logic signed [DEF_DATA_WIDTH+12:0] sum_t;

    function automatic int chroma_offset(input int dw);
        return 1 << (dw - 1);
    endfunction

endpackage

// File: rtl/ycbcr_to_rgb_clamp_shift.sv
// rtl/ycbcr_to_rgb_clamp_shift.sv - floor shift by COEF_FRAC and saturate to unsigned DATA_WIDTH
module clamp_shift #(
    parameter int DATA_WIDTH = 8,
    parameter int COEF_FRAC  = 8
) (
    input  logic signed [DATA_WIDTH+12:0] in_sum,
    output logic        [DATA_WIDTH-1:0]  out_data
);

    localparam int SW = DATA_WIDTH + 13;

    logic signed [SW-1:0] shifted;

    always_comb begin
        shifted  = in_sum >>> COEF_FRAC;
        out_data = shifted[DATA_WIDTH-1:0];
        if (shifted[SW-1]) begin
            out_data = '0;
        end else if (|shifted[SW-2:DATA_WIDTH]) begin
            out_data = '1;
        end
    end

endmodule

// File: rtl/ycbcr_to_rgb.sv
// rtl/ycbcr_to_rgb.sv - 4-stage BT.601 YCbCr->RGB converter; YCBCR_TO_RGB_STUDIO_RANGE_EN selects studio range
module ycbcr_to_rgb
    import ycbcr_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int COEF_FRAC  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_y_data,
    input  logic [DATA_WIDTH-1:0] in_cb_data,
    input  logic [DATA_WIDTH-1:0] in_cr_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_r_data,
    output logic [DATA_WIDTH-1:0] out_g_data,
    output logic [DATA_WIDTH-1:0] out_b_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int CW = DATA_WIDTH + 1;
    localparam int PW = DATA_WIDTH + 12;
    localparam int SW = DATA_WIDTH + 13;

`ifdef YCBCR_TO_RGB_STUDIO_RANGE_EN
    localparam int K_Y   = STUDIO_K_Y;
    localparam int K_RCR = STUDIO_K_RCR;
    localparam int K_GCB = STUDIO_K_GCB;
    localparam int K_GCR = STUDIO_K_GCR;
    localparam int K_BCB = STUDIO_K_BCB;
    localparam int Y_OFF = STUDIO_Y_OFF;
`else
    localparam int K_Y   = FULL_K_Y;
    localparam int K_RCR = FULL_K_RCR;
    localparam int K_GCB = FULL_K_GCB;
    localparam int K_GCR = FULL_K_GCR;
    localparam int K_BCB = FULL_K_BCB;
    localparam int Y_OFF = FULL_Y_OFF;
`endif

    localparam logic signed [PW-1:0] KY_S   = PW'(K_Y);
    localparam logic signed [PW-1:0] KRCR_S = PW'(K_RCR);
    localparam logic signed [PW-1:0] KGCB_S = PW'(K_GCB);
    localparam logic signed [PW-1:0] KGCR_S = PW'(K_GCR);
    localparam logic signed [PW-1:0] KBCB_S = PW'(K_BCB);
    localparam logic signed [CW-1:0] YOFF_S = CW'(Y_OFF);
    localparam logic signed [CW-1:0] COFF_S = CW'(chroma_offset(DATA_WIDTH));

    logic en;

    logic                  v1_q, v1_d;
    logic signed [CW-1:0]  yd1_q, yd1_d, cb1_q, cb1_d, cr1_q, cr1_d;

    logic                  v2_q, v2_d;
    logic signed [PW-1:0]  py2_q, py2_d, prcr2_q, prcr2_d;
    logic signed [PW-1:0]  pgcb2_q, pgcb2_d, pgcr2_q, pgcr2_d, pbcb2_q, pbcb2_d;

    logic                  v3_q, v3_d;
    logic signed [SW-1:0]  r3_q, r3_d, g3_q, g3_d, b3_q, b3_d;

    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_r_q, out_r_d, out_g_q, out_g_d, out_b_q, out_b_d;
    logic [DATA_WIDTH-1:0] r_cl, g_cl, b_cl;

    // Whole pipeline advances together; a stalled output freezes every stage
    always_comb begin
        en          = out_ready | ~out_valid_q;

        v1_d        = in_valid;
        yd1_d       = $signed({1'b0, in_y_data}) - YOFF_S;
        cb1_d       = $signed({1'b0, in_cb_data}) - COFF_S;
        cr1_d       = $signed({1'b0, in_cr_data}) - COFF_S;

        v2_d        = v1_q;
        py2_d       = PW'(yd1_q) * KY_S;
        prcr2_d     = PW'(cr1_q) * KRCR_S;
        pgcb2_d     = PW'(cb1_q) * KGCB_S;
        pgcr2_d     = PW'(cr1_q) * KGCR_S;
        pbcb2_d     = PW'(cb1_q) * KBCB_S;

        v3_d        = v2_q;
        r3_d        = SW'(py2_q) + SW'(prcr2_q);
        g3_d        = SW'(py2_q) - SW'(pgcb2_q) - SW'(pgcr2_q);
        b3_d        = SW'(py2_q) + SW'(pbcb2_q);

        out_valid_d = v3_q;
        out_r_d     = r_cl;
        out_g_d     = g_cl;
        out_b_d     = b_cl;
    end

    clamp_shift #(.DATA_WIDTH(DATA_WIDTH), .COEF_FRAC(COEF_FRAC)) u_clamp_r (.in_sum(r3_q), .out_data(r_cl));
    clamp_shift #(.DATA_WIDTH(DATA_WIDTH), .COEF_FRAC(COEF_FRAC)) u_clamp_g (.in_sum(g3_q), .out_data(g_cl));
    clamp_shift #(.DATA_WIDTH(DATA_WIDTH), .COEF_FRAC(COEF_FRAC)) u_clamp_b (.in_sum(b3_q), .out_data(b_cl));

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q        <= 1'b0;
            yd1_q       <= '0;
            cb1_q       <= '0;
            cr1_q       <= '0;
            v2_q        <= 1'b0;
            py2_q       <= '0;
            prcr2_q     <= '0;
            pgcb2_q     <= '0;
            pgcr2_q     <= '0;
            pbcb2_q     <= '0;
            v3_q        <= 1'b0;
            r3_q        <= '0;
            g3_q        <= '0;
            b3_q        <= '0;
            out_valid_q <= 1'b0;
            out_r_q     <= '0;
            out_g_q     <= '0;
            out_b_q     <= '0;
        end else if (en) begin
            v1_q        <= v1_d;
            yd1_q       <= yd1_d;
            cb1_q       <= cb1_d;
            cr1_q       <= cr1_d;
            v2_q        <= v2_d;
            py2_q       <= py2_d;
            prcr2_q     <= prcr2_d;
            pgcb2_q     <= pgcb2_d;
            pgcr2_q     <= pgcr2_d;
            pbcb2_q     <= pbcb2_d;
            v3_q        <= v3_d;
            r3_q        <= r3_d;
            g3_q        <= g3_d;
            b3_q        <= b3_d;
            out_valid_q <= out_valid_d;
            out_r_q     <= out_r_d;
            out_g_q     <= out_g_d;
            out_b_q     <= out_b_d;
        end
    end

    assign in_ready   = en;
    assign out_valid  = out_valid_q;
    assign out_r_data = out_r_q;
    assign out_g_data = out_g_q;
    assign out_b_data = out_b_q;

endmodule

// File: tb/tb_ycbcr_to_rgb.sv
// tb/tb_ycbcr_to_rgb.sv - scoreboard bench for ycbcr_to_rgb; honours YCBCR_TO_RGB_STUDIO_RANGE_EN
module tb_ycbcr_to_rgb;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_y_data, in_cb_data, in_cr_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_r_data, out_g_data, out_b_data;
    logic       out_valid;
    logic       out_ready;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [23:0] rgb;
        int          issue;
        bit          lat;
    } exp_t;

    exp_t sb[$];

    ycbcr_to_rgb #(.DATA_WIDTH(8), .COEF_FRAC(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_y_data  (in_y_data),
        .in_cb_data (in_cb_data),
        .in_cr_data (in_cr_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_r_data (out_r_data),
        .out_g_data (out_g_data),
        .out_b_data (out_b_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int floor256(input int a);
        if (a >= 0) return a / 256;
        return -((-a + 255) / 256);
    endfunction

    function automatic logic [7:0] clip8(input int v);
        if (v < 0) return 8'd0;
        if (v > 255) return 8'd255;
        return v[7:0];
    endfunction

    // Reference: BT.601 equations with integer coefficients, floor division and clamping
    function automatic logic [23:0] ref_rgb(input int y, input int cb, input int cr);
        int cbp = cb - 128;
        int crp = cr - 128;
        int r, g, b;
`ifdef YCBCR_TO_RGB_STUDIO_RANGE_EN
        int ys = 298 * (y - 16);
        r = ys + 409 * crp;
        g = ys - 100 * cbp - 208 * crp;
        b = ys + 516 * cbp;
`else
        int ys = 256 * y;
        r = ys + 359 * crp;
        g = ys - 88 * cbp - 183 * crp;
        b = ys + 454 * cbp;
`endif
        return {clip8(floor256(r)), clip8(floor256(g)), clip8(floor256(b))};
    endfunction

    task automatic drive_px(input logic [23:0] ycc, input logic [23:0] exp, input bit lat, input bit rnd_ready);
        exp_t e;
        int guard = 0;
        @(negedge clk);
        {in_y_data, in_cb_data, in_cr_data} = ycc;
        in_valid = 1'b1;
        forever begin
            if (rnd_ready) out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (in_ready) begin
                e.rgb   = exp;
                e.issue = cyc;
                e.lat   = lat;
                sb.push_back(e);
                break;
            end
            guard++;
            if (guard > 100) begin
                chk("input_accept_timeout", 32'd0, 32'd1);
                break;
            end
            @(negedge clk);
        end
    endtask

    // Monitor: everything here is evaluated before the next rising edge
    initial forever begin
        exp_t e;
        @(negedge clk);
        #2;
        if (!rst && out_valid && !out_ready) chk("in_ready_when_stalled", {31'd0, in_ready}, 32'd0);
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", {8'd0, out_r_data, out_g_data, out_b_data}, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("rgb", {8'd0, out_r_data, out_g_data, out_b_data}, {8'd0, e.rgb});
                if (e.lat) chk("latency", cyc - e.issue, 32'd4);
            end
        end
    end

`ifdef YCBCR_TO_RGB_STUDIO_RANGE_EN
    localparam int NDIR = 4;
    logic [23:0] dir_in[NDIR]  = '{24'hEB8080, 24'h108080, 24'h101010, 24'h808080};
    logic [23:0] dir_exp[NDIR] = '{24'hFEFEFE, 24'h000000, 24'h008600, 24'h828282};
`else
    localparam int NDIR = 5;
    logic [23:0] dir_in[NDIR]  = '{24'h808080, 24'hFF80FF, 24'h000000, 24'h4C55FF, 24'hFF8080};
    logic [23:0] dir_exp[NDIR] = '{24'h808080, 24'hFFA4FF, 24'h008700, 24'hFE0000, 24'hFFFFFF};
`endif

    initial begin
        logic [23:0] px;
        int          guard;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_y_data  = '0;
        in_cb_data = '0;
        in_cr_data = '0;
        out_ready  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_out_data", {8'd0, out_r_data, out_g_data, out_b_data}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

        out_ready = 1'b1;
        for (int i = 0; i < NDIR; i++) drive_px(dir_in[i], dir_exp[i], 1'b1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            px = 24'($urandom);
            drive_px(px, ref_rgb(px[23:16], px[15:8], px[7:0]), 1'b0, 1'b1);
        end

        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            px = 24'($urandom);
            drive_px(px, ref_rgb(px[23:16], px[15:8], px[7:0]), 1'b0, 1'b0);
        end
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sb.delete();
        @(negedge clk);
        #1;
        chk("midreset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midreset_out_data", {8'd0, out_r_data, out_g_data, out_b_data}, 32'd0);
        rst       = 1'b0;
        out_ready = 1'b1;
        drive_px(dir_in[0], dir_exp[0], 1'b1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;

        guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("drain_empty", sb.size(), 32'd0);
        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
